// File: rtl/decode_stage_pkg.sv
// Shared constants for the RV32I decode stage: opcodes, ALU/result-select codes,
// immediate formats and the immediate extender used by the decoder.
package decode_stage_pkg;

    localparam int XLEN  = 32;
    localparam int RF_AW = 5;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_fmt_e;

    // Branch and jump offsets are halfword-aligned, hence the forced zero LSB.
    function automatic logic [XLEN-1:0] imm_extend(input logic [XLEN-1:0] instr,
                                                   input imm_fmt_e fmt);
        logic [XLEN-1:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of fetch inputs, writeback port and ID/EX-bound decode outputs.
// master = the environment driving the stage, slave = the decode stage itself.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic [XLEN-1:0]  instr_rd_f;
    logic [XLEN-1:0]  pc_f;
    logic [XLEN-1:0]  pc_plus4_f;
    logic             stall_d;
    logic             flush_d;
    logic             reg_write_w;
    logic [RF_AW-1:0] rd_w;
    logic [XLEN-1:0]  result_w;

    logic [XLEN-1:0]  rd1_d;
    logic [XLEN-1:0]  rd2_d;
    logic [XLEN-1:0]  imm_ext_d;
    logic [RF_AW-1:0] rs1_d;
    logic [RF_AW-1:0] rs2_d;
    logic [RF_AW-1:0] rd_d;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  pc_plus4_d;
    logic             reg_write_d;
    logic [1:0]       result_src_d;
    logic             mem_write_d;
    logic             jump_d;
    logic             branch_d;
    logic [2:0]       alu_ctrl_d;
    logic             alu_src_d;
    logic             illegal_d;

    modport master (
        output instr_rd_f, pc_f, pc_plus4_f, stall_d, flush_d,
               reg_write_w, rd_w, result_w,
        input  rd1_d, rd2_d, imm_ext_d, rs1_d, rs2_d, rd_d, pc_d, pc_plus4_d,
               reg_write_d, result_src_d, mem_write_d, jump_d, branch_d,
               alu_ctrl_d, alu_src_d, illegal_d
    );

    modport slave (
        input  instr_rd_f, pc_f, pc_plus4_f, stall_d, flush_d,
               reg_write_w, rd_w, result_w,
        output rd1_d, rd2_d, imm_ext_d, rs1_d, rs2_d, rd_d, pc_d, pc_plus4_d,
               reg_write_d, result_src_d, mem_write_d, jump_d, branch_d,
               alu_ctrl_d, alu_src_d, illegal_d
    );

endinterface

// File: rtl/decode_stage_register_file.sv
// 32x32 register file: two async read ports, one sync write port, x0 hard-wired
// to zero, and write-through so a WB write is visible to decode in the same cycle.
module register_file
    import decode_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [RF_AW-1:0] i_ra1,
    input  logic [RF_AW-1:0] i_ra2,
    input  logic             i_we,
    input  logic [RF_AW-1:0] i_wa,
    input  logic [XLEN-1:0]  i_wd,
    output logic [XLEN-1:0]  o_rd1,
    output logic [XLEN-1:0]  o_rd2
);

    logic [XLEN-1:0] r_regs [2**RF_AW];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_wa != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**RF_AW; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == '0)                ? '0   :
                   (w_wr_en && (i_wa == i_ra1)) ? i_wd : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == '0)                ? '0   :
                   (w_wr_en && (i_wa == i_ra2)) ? i_wd : r_regs[i_ra2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID pipeline register, register file read, immediate
// extension and main/ALU control decode feeding the ID/EX register.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave dec
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    // Flush beats stall so a squashed slot never lingers while the front end is held.
    always_ff @(posedge clk) begin
        if (rst || dec.flush_d) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (!dec.stall_d) begin
            r_instr    <= dec.instr_rd_f;
            r_pc       <= dec.pc_f;
            r_pc_plus4 <= dec.pc_plus4_f;
            r_valid    <= 1'b1;
        end
    end

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_is_rtype;
    logic [2:0] w_alu_op;
    logic       w_alu_ok;
    imm_fmt_e   w_imm_fmt;

    assign w_opcode   = r_instr[6:0];
    assign w_funct3   = r_instr[14:12];
    assign w_is_rtype = (w_opcode == OP_RTYPE);

    assign dec.rs1_d      = r_instr[19:15];
    assign dec.rs2_d      = r_instr[24:20];
    assign dec.rd_d       = r_instr[11:7];
    assign dec.pc_d       = r_pc;
    assign dec.pc_plus4_d = r_pc_plus4;

    always_comb begin
        w_alu_op = ALU_ADD;
        w_alu_ok = 1'b1;
        case (w_funct3)
            3'b000:  w_alu_op = (w_is_rtype && r_instr[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_op = ALU_SLT;
            3'b110:  w_alu_op = ALU_OR;
            3'b111:  w_alu_op = ALU_AND;
            default: w_alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec.reg_write_d  = 1'b0;
        dec.result_src_d = RES_ALU;
        dec.mem_write_d  = 1'b0;
        dec.jump_d       = 1'b0;
        dec.branch_d     = 1'b0;
        dec.alu_ctrl_d   = ALU_ADD;
        dec.alu_src_d    = 1'b0;
        dec.illegal_d    = 1'b0;
        w_imm_fmt        = IMM_NONE;
        if (r_valid) begin
            case (w_opcode)
                OP_LOAD: begin
                    dec.reg_write_d  = 1'b1;
                    dec.result_src_d = RES_MEM;
                    dec.alu_src_d    = 1'b1;
                    w_imm_fmt        = IMM_I;
                end
                OP_STORE: begin
                    dec.mem_write_d = 1'b1;
                    dec.alu_src_d   = 1'b1;
                    w_imm_fmt       = IMM_S;
                end
                OP_BRANCH: begin
                    dec.branch_d   = 1'b1;
                    dec.alu_ctrl_d = ALU_SUB;
                    w_imm_fmt      = IMM_B;
                end
                OP_JAL: begin
                    dec.jump_d       = 1'b1;
                    dec.reg_write_d  = 1'b1;
                    dec.result_src_d = RES_PC4;
                    w_imm_fmt        = IMM_J;
                end
                OP_RTYPE, OP_IALU: begin
                    if (w_alu_ok) begin
                        dec.reg_write_d = 1'b1;
                        dec.alu_ctrl_d  = w_alu_op;
                        dec.alu_src_d   = !w_is_rtype;
                        w_imm_fmt       = w_is_rtype ? IMM_NONE : IMM_I;
                    end else begin
                        dec.illegal_d = 1'b1;
                    end
                end
                default: dec.illegal_d = 1'b1;
            endcase
        end
    end

    assign dec.imm_ext_d = imm_extend(r_instr, w_imm_fmt);

    register_file u_register_file (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (r_instr[19:15]),
        .i_ra2 (r_instr[24:20]),
        .i_we  (dec.reg_write_w),
        .i_wa  (dec.rd_w),
        .i_wd  (dec.result_w),
        .o_rd1 (dec.rd1_d),
        .o_rd2 (dec.rd2_d)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a reference model of IF/ID, register file and
// decoder pushes expected outputs to a scoreboard that is popped after each step.
module tb_decode_stage;

    logic clk;
    logic rst;

    decode_stage_if dif ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .dec (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw;
        logic        jmp;
        logic        br;
        logic [2:0]  alu;
        logic        asrc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;

    logic [31:0] mRf [32];
    logic [31:0] mInstr;
    logic [31:0] mPc;
    logic [31:0] mPc4;
    logic        mValid;
    logic [31:0] fetchPc;
    logic        cWe;
    logic [4:0]  cWa;
    logic [31:0] cWd;
    logic [31:0] heldPc;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t decodeModel(input logic [31:0] ins, input logic v);
        exp_t e;
        logic isR;
        e     = '0;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        isR   = (ins[6:0] == 7'b0110011);
        if (v) begin
            case (ins[6:0])
                7'b0000011: begin
                    e.rw = 1; e.rsrc = 2'b01; e.asrc = 1;
                    e.imm = {{20{ins[31]}}, ins[31:20]};
                end
                7'b0100011: begin
                    e.mw = 1; e.asrc = 1;
                    e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                end
                7'b1100011: begin
                    e.br = 1; e.alu = 3'b001;
                    e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                end
                7'b1101111: begin
                    e.jmp = 1; e.rw = 1; e.rsrc = 2'b10;
                    e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                end
                7'b0110011, 7'b0010011: begin
                    case (ins[14:12])
                        3'b000:  e.alu = (isR && ins[30]) ? 3'b001 : 3'b000;
                        3'b010:  e.alu = 3'b101;
                        3'b110:  e.alu = 3'b011;
                        3'b111:  e.alu = 3'b010;
                        default: e.ill = 1;
                    endcase
                    if (!e.ill) begin
                        e.rw   = 1;
                        e.asrc = !isR;
                        e.imm  = isR ? 32'h0 : {{20{ins[31]}}, ins[31:20]};
                    end
                end
                default: e.ill = 1;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rfRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (cWe && cWa != 5'd0 && cWa == idx) return cWd;
        return mRf[idx];
    endfunction

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e     = decodeModel(mInstr, mValid);
        e.pc  = mPc;
        e.pc4 = mPc4;
        e.rd1 = rfRead(e.rs1);
        e.rd2 = rfRead(e.rs2);
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string step);
        exp_t e;
        if (sb.size() == 0) begin
            checkField({step, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        checkField({step, "_rd1"},  dif.rd1_d,        e.rd1);
        checkField({step, "_rd2"},  dif.rd2_d,        e.rd2);
        checkField({step, "_imm"},  dif.imm_ext_d,    e.imm);
        checkField({step, "_pc"},   dif.pc_d,         e.pc);
        checkField({step, "_pc4"},  dif.pc_plus4_d,   e.pc4);
        checkField({step, "_rs1"},  {27'd0, dif.rs1_d}, {27'd0, e.rs1});
        checkField({step, "_rs2"},  {27'd0, dif.rs2_d}, {27'd0, e.rs2});
        checkField({step, "_rd"},   {27'd0, dif.rd_d},  {27'd0, e.rd});
        checkField({step, "_rw"},   {31'd0, dif.reg_write_d}, {31'd0, e.rw});
        checkField({step, "_rsrc"}, {30'd0, dif.result_src_d}, {30'd0, e.rsrc});
        checkField({step, "_mw"},   {31'd0, dif.mem_write_d}, {31'd0, e.mw});
        checkField({step, "_jmp"},  {31'd0, dif.jump_d}, {31'd0, e.jmp});
        checkField({step, "_br"},   {31'd0, dif.branch_d}, {31'd0, e.br});
        checkField({step, "_alu"},  {29'd0, dif.alu_ctrl_d}, {29'd0, e.alu});
        checkField({step, "_asrc"}, {31'd0, dif.alu_src_d}, {31'd0, e.asrc});
        checkField({step, "_ill"},  {31'd0, dif.illegal_d}, {31'd0, e.ill});
    endtask

    // One clock step: drive F/WB/control inputs, advance the model across the edge, check.
    task automatic applyStimulus(input string step, input logic [31:0] instr,
                                 input logic st, input logic fl, input logic rs,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        dif.instr_rd_f  = instr;
        dif.pc_f        = fetchPc;
        dif.pc_plus4_f  = fetchPc + 32'd4;
        dif.stall_d     = st;
        dif.flush_d     = fl;
        dif.reg_write_w = we;
        dif.rd_w        = wa;
        dif.result_w    = wd;
        rst             = rs;
        cWe = we; cWa = wa; cWd = wd;
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 32; i++) mRf[i] = 32'h0;
            mInstr = 32'h0000_0013; mPc = 0; mPc4 = 0; mValid = 0;
        end else begin
            if (we && wa != 5'd0) mRf[wa] = wd;
            if (fl) begin
                mInstr = 32'h0000_0013; mPc = 0; mPc4 = 0; mValid = 0;
            end else if (!st) begin
                mInstr = instr; mPc = fetchPc; mPc4 = fetchPc + 32'd4; mValid = 1;
            end
        end
        fetchPc = fetchPc + 32'd4;
        #1;
        pushExpected();
        checkOutput(step);
    endtask

    // Change only the WB port between edges to exercise the write-through path.
    task automatic setWbOnly(input string step, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd);
        dif.reg_write_w = we;
        dif.rd_w        = wa;
        dif.result_w    = wd;
        cWe = we; cWa = wa; cWd = wd;
        #1;
        pushExpected();
        checkOutput(step);
    endtask

    initial begin
        fetchPc = 32'h0000_1000;
        cWe = 0; cWa = 0; cWd = 0;
        mInstr = 32'h0000_0013; mPc = 0; mPc4 = 0; mValid = 0;
        for (int i = 0; i < 32; i++) mRf[i] = 32'hX;
        dif.instr_rd_f = 0; dif.pc_f = 0; dif.pc_plus4_f = 0;
        dif.stall_d = 0; dif.flush_d = 0;
        dif.reg_write_w = 0; dif.rd_w = 0; dif.result_w = 0;
        rst = 1;
        #2;

        applyStimulus("rst0", 32'h0000_0013, 0, 0, 1, 0, 0, 0);
        applyStimulus("pre_wr", 32'h0050_0093, 0, 0, 0, 1, 5'd5, 32'h0000_0055);
        applyStimulus("rst1", 32'h0050_0093, 0, 0, 1, 1, 5'd6, 32'h0000_0066);
        applyStimulus("rst2", 32'h0050_0093, 0, 0, 1, 0, 0, 0);
        checkField("rst_pc_d", dif.pc_d, 32'h0);
        checkField("rst_rw", {31'd0, dif.reg_write_d}, 32'h0);

        applyStimulus("post_rst", 32'h0062_83B3, 0, 0, 0, 0, 0, 0);
        checkField("post_rst_x5", dif.rd1_d, 32'h0);
        checkField("post_rst_x6", dif.rd2_d, 32'h0);

        applyStimulus("add_wb", 32'h0002_83B3, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
        checkField("add_rd1", dif.rd1_d, 32'hDEAD_BEEF);
        setWbOnly("bypass", 1, 5'd5, 32'hCAFE_F00D);
        checkField("bypass_rd1", dif.rd1_d, 32'hCAFE_F00D);
        setWbOnly("bypass_off", 0, 5'd0, 32'h0);

        applyStimulus("beq", 32'hFE20_8CE3, 0, 0, 0, 0, 0, 0);
        checkField("beq_imm", dif.imm_ext_d, 32'hFFFF_FFF8);
        applyStimulus("jal", 32'h0010_00EF, 0, 0, 0, 0, 0, 0);
        checkField("jal_imm", dif.imm_ext_d, 32'h0000_0800);
        applyStimulus("lw", 32'hFFC0_A403, 0, 0, 0, 1, 5'd1, 32'h0000_0100);
        applyStimulus("sub", 32'h4020_81B3, 0, 0, 0, 1, 5'd2, 32'h0000_0007);
        applyStimulus("and", 32'h0020_F233, 0, 0, 0, 0, 0, 0);
        applyStimulus("or", 32'h0020_E2B3, 0, 0, 0, 0, 0, 0);
        applyStimulus("slt", 32'h0020_A333, 0, 0, 0, 0, 0, 0);
        applyStimulus("slti", 32'h0050_A313, 0, 0, 0, 0, 0, 0);
        applyStimulus("andi_neg", 32'hF0F0_F393, 0, 0, 0, 0, 0, 0);

        applyStimulus("sw", 32'h0061_2623, 0, 0, 0, 0, 0, 0);
        heldPc = fetchPc - 32'd4;
        checkField("sw_imm", dif.imm_ext_d, 32'h0000_000C);
        applyStimulus("stall1", 32'h0020_E2B3, 1, 0, 0, 0, 0, 0);
        applyStimulus("stall2", 32'h0010_00EF, 1, 0, 0, 0, 0, 0);
        applyStimulus("stall3", 32'hFE20_8CE3, 1, 0, 0, 0, 0, 0);
        checkField("stall_pc_held", dif.pc_d, heldPc);
        applyStimulus("flush_stall", 32'h0020_E2B3, 1, 1, 0, 0, 0, 0);
        checkField("flush_mw", {31'd0, dif.mem_write_d}, 32'h0);

        applyStimulus("addi_x0", 32'h0050_0093, 0, 0, 0, 0, 0, 0);
        setWbOnly("x0_wr_comb", 1, 5'd0, 32'h0000_1234);
        checkField("x0_same_cycle", dif.rd1_d, 32'h0);
        applyStimulus("x0_wr_edge", 32'h0050_0093, 1, 0, 0, 1, 5'd0, 32'h0000_1234);
        checkField("x0_next_cycle", dif.rd1_d, 32'h0);

        applyStimulus("bad_op", 32'h0000_007F, 0, 0, 0, 0, 0, 0);
        checkField("bad_op_ill", {31'd0, dif.illegal_d}, 32'h1);
        applyStimulus("bad_f3", 32'h0002_93B3, 0, 0, 0, 0, 0, 0);
        checkField("bad_f3_ill", {31'd0, dif.illegal_d}, 32'h1);
        checkField("bad_f3_rw", {31'd0, dif.reg_write_d}, 32'h0);
        applyStimulus("flush_only", 32'h0002_83B3, 0, 1, 0, 0, 0, 0);
        applyStimulus("reload", 32'h0002_83B3, 0, 0, 0, 0, 0, 0);

        checkField("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
